// File: rtl/packet_receiver.sv
// AXI4-Stream RX sink: classifies generator UDP test packets and measures one-way latency.
// Optional sequence-number checking is enabled by defining RX_SEQ_CHECK_EN.
module packet_receiver #(
    parameter int TIMESTAMP_WIDTH      = 64,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [TIMESTAMP_WIDTH-1:0]        stamp_counter,
    input  logic [15:0]                       cfg_udp_dstport,
    input  logic                              clear_stats,
    output logic [31:0]                       rx_packets,
    output logic [31:0]                       rx_matched,
    output logic [31:0]                       rx_runts,
    output logic [31:0]                       rx_bytes,
    output logic [31:0]                       ts_errors,
    output logic [31:0]                       lat_last,
    output logic [31:0]                       lat_min,
    output logic [31:0]                       lat_max,
    output logic [31:0]                       seq_errors
);

    localparam logic [31:0] SAT32   = 32'hFFFF_FFFF;
    localparam int          TS_BYTE = 10;  // packet byte 42 sits at byte 10 of beat 1
    localparam int          SQ_BYTE = 18;  // packet byte 50 sits at byte 18 of beat 1

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == SAT32) ? SAT32 : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [5:0] n);
        logic [32:0] s;
        s = {1'b0, v} + {27'd0, n};
        return s[32] ? SAT32 : s[31:0];
    endfunction

    function automatic logic [31:0] lat_sat(input logic [63:0] d);
        return (d[63:32] != 32'd0) ? SAT32 : d[31:0];
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_tready;
    logic        r_hdr_ok0;

    logic        w_beat;
    logic        w_hdr_cap;
    logic        w_beat1;
    logic        w_pkt_end;
    logic        w_runt;
    logic        w_hdr_ok;
    logic [15:0] w_dport;
    logic        w_match;
    logic [63:0] w_ts;
    logic        w_ts_err;
    logic [63:0] w_diff;
    logic [31:0] w_lat;
    logic        w_unused;

    logic [31:0] r_rx_packets;
    logic [31:0] r_rx_matched;
    logic [31:0] r_rx_runts;
    logic [31:0] r_rx_bytes;
    logic [31:0] r_ts_errors;
    logic [31:0] r_lat_last;
    logic [31:0] r_lat_min;
    logic [31:0] r_lat_max;

    assign w_unused = ^{s_axis_tuser, s_axis_tdata};

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) r_tready <= 1'b0;
        else             r_tready <= 1'b1;
    end

    assign s_axis_tready = r_tready;
    assign w_beat        = s_axis_tvalid & r_tready;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) r_state <= S_FIRST;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_beat) begin
            unique case (r_state)
                S_FIRST:  if (!s_axis_tlast) w_state_nxt = S_SECOND;
                S_SECOND: w_state_nxt = s_axis_tlast ? S_FIRST : S_DRAIN;
                S_DRAIN:  if (s_axis_tlast) w_state_nxt = S_FIRST;
                default:  w_state_nxt = S_FIRST;
            endcase
        end
    end

    always_comb begin
        w_hdr_cap = 1'b0;
        w_beat1   = 1'b0;
        w_runt    = 1'b0;
        w_pkt_end = w_beat & s_axis_tlast;
        unique case (r_state)
            S_FIRST: begin
                w_hdr_cap = w_beat;
                w_runt    = w_beat & s_axis_tlast;
            end
            S_SECOND: w_beat1 = w_beat;
            default: ;
        endcase
    end

    // Beat 0: Ethertype IPv4, IHL=5, protocol UDP
    assign w_hdr_ok = ({s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]} == 16'h0800) &&
                      (s_axis_tdata[8*14 +: 8] == 8'h45) &&
                      (s_axis_tdata[8*23 +: 8] == 8'd17);

    always_ff @(posedge axi_aclk) begin
        if (w_hdr_cap) r_hdr_ok0 <= w_hdr_ok;
    end

    // Beat 1: destination port, big-endian timestamp, latency
    assign w_dport = {s_axis_tdata[8*4 +: 8], s_axis_tdata[8*5 +: 8]};
    assign w_match = w_beat1 & r_hdr_ok0 & (w_dport == cfg_udp_dstport);

    always_comb begin
        w_ts = 64'd0;
        for (int i = 0; i < 8; i++) w_ts[63-8*i -: 8] = s_axis_tdata[8*(TS_BYTE+i) +: 8];
    end

    assign w_ts_err = (w_ts > stamp_counter);
    assign w_diff   = stamp_counter - w_ts;
    assign w_lat    = lat_sat(w_diff);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn || clear_stats) begin
            r_rx_packets <= 32'd0;
            r_rx_matched <= 32'd0;
            r_rx_runts   <= 32'd0;
            r_rx_bytes   <= 32'd0;
            r_ts_errors  <= 32'd0;
            r_lat_last   <= 32'd0;
            r_lat_min    <= SAT32;
            r_lat_max    <= 32'd0;
        end else begin
            if (w_pkt_end) r_rx_packets <= sat_inc(r_rx_packets);
            if (w_runt)    r_rx_runts   <= sat_inc(r_rx_runts);
            if (w_beat)    r_rx_bytes   <= sat_add(r_rx_bytes, popcount32(s_axis_tstrb));
            if (w_match) begin
                r_rx_matched <= sat_inc(r_rx_matched);
                if (w_ts_err) begin
                    r_ts_errors <= sat_inc(r_ts_errors);
                end else begin
                    r_lat_last <= w_lat;
                    if (w_lat < r_lat_min) r_lat_min <= w_lat;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                end
            end
        end
    end

    assign rx_packets = r_rx_packets;
    assign rx_matched = r_rx_matched;
    assign rx_runts   = r_rx_runts;
    assign rx_bytes   = r_rx_bytes;
    assign ts_errors  = r_ts_errors;
    assign lat_last   = r_lat_last;
    assign lat_min    = r_lat_min;
    assign lat_max    = r_lat_max;

`ifdef RX_SEQ_CHECK_EN
    logic [31:0] w_seq;
    logic        r_seq_seeded;
    logic [31:0] r_seq_exp;
    logic [31:0] r_seq_errors;

    assign w_seq = {s_axis_tdata[8*SQ_BYTE     +: 8], s_axis_tdata[8*(SQ_BYTE+1) +: 8],
                    s_axis_tdata[8*(SQ_BYTE+2) +: 8], s_axis_tdata[8*(SQ_BYTE+3) +: 8]};

    // First match after reset/clear only seeds the expectation
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn || clear_stats) begin
            r_seq_seeded <= 1'b0;
            r_seq_exp    <= 32'd0;
            r_seq_errors <= 32'd0;
        end else if (w_match) begin
            r_seq_seeded <= 1'b1;
            r_seq_exp    <= w_seq + 32'd1;
            if (r_seq_seeded && (w_seq != r_seq_exp)) r_seq_errors <= sat_inc(r_seq_errors);
        end
    end

    assign seq_errors = r_seq_errors;
`else
    assign seq_errors = 32'd0;
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// Randomized scoreboard bench for packet_receiver against a byte-level packet model.
module tb_packet_receiver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] tdata;
    logic [31:0]  tstrb;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [63:0]  stamp;
    logic [15:0]  cfg_dport;
    logic         clear_stats;
    logic [31:0]  rx_packets, rx_matched, rx_runts, rx_bytes, ts_errors;
    logic [31:0]  lat_last, lat_min, lat_max, seq_errors;

    always #5 clk = ~clk;

    packet_receiver dut (
        .axi_aclk        (clk),
        .axi_resetn      (rst_n),
        .s_axis_tdata    (tdata),
        .s_axis_tstrb    (tstrb),
        .s_axis_tuser    (tuser),
        .s_axis_tvalid   (tvalid),
        .s_axis_tready   (tready),
        .s_axis_tlast    (tlast),
        .stamp_counter   (stamp),
        .cfg_udp_dstport (cfg_dport),
        .clear_stats     (clear_stats),
        .rx_packets      (rx_packets),
        .rx_matched      (rx_matched),
        .rx_runts        (rx_runts),
        .rx_bytes        (rx_bytes),
        .ts_errors       (ts_errors),
        .lat_last        (lat_last),
        .lat_min         (lat_min),
        .lat_max         (lat_max),
        .seq_errors      (seq_errors)
    );

    typedef struct {
        longint unsigned packets, matched, runts, bytes, ts_err;
        longint unsigned lat_last, lat_min, lat_max, seq_err;
    } snap_t;

    snap_t           exp_q[$];
    snap_t           m;
    bit              m_seq_seeded;
    longint unsigned m_seq_exp;
    byte unsigned    pkt[0:127];
    logic [31:0]     pstrb[0:3];
    int              n_vec = 0;
    int              n_err = 0;
    logic [31:0]     prev_pk = 32'd0;

    function automatic longint unsigned sat(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        m = '{default: 0};
        m.lat_min    = 64'hFFFF_FFFF;
        m_seq_seeded = 1'b0;
        m_seq_exp    = 0;
    endtask

    // Packet-level model: whole packet in pkt[], stamp value seen on beat 1
    task automatic model_packet(input int nb, input longint unsigned st);
        longint unsigned ts, lat, sq;
        int nbytes;
        nbytes = 0;
        m.packets = sat(m.packets + 1);
        for (int b = 0; b < nb; b++) nbytes += $countones(pstrb[b]);
        m.bytes = sat(m.bytes + longint'(nbytes));
        if (nb == 1) begin
            m.runts = sat(m.runts + 1);
        end else if ({pkt[12], pkt[13]} == 16'h0800 && pkt[14] == 8'h45 && pkt[23] == 8'd17 &&
                     {pkt[36], pkt[37]} == cfg_dport) begin
            m.matched = sat(m.matched + 1);
            ts = 0;
            for (int i = 42; i <= 49; i++) ts = (ts << 8) | longint'(pkt[i]);
            if (ts > st) begin
                m.ts_err = sat(m.ts_err + 1);
            end else begin
                lat = sat(st - ts);
                m.lat_last = lat;
                if (lat < m.lat_min) m.lat_min = lat;
                if (lat > m.lat_max) m.lat_max = lat;
            end
`ifdef RX_SEQ_CHECK_EN
            sq = 0;
            for (int i = 50; i <= 53; i++) sq = (sq << 8) | longint'(pkt[i]);
            if (m_seq_seeded && sq != m_seq_exp) m.seq_err = sat(m.seq_err + 1);
            m_seq_exp    = (sq + 1) & 64'hFFFF_FFFF;
            m_seq_seeded = 1'b1;
`else
            sq = 0;
`endif
        end
    endtask

    task automatic build_pkt(input bit good_hdr, input bit good_port,
                             input longint unsigned ts, input int unsigned sq);
        int k;
        for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom);
        for (int b = 0; b < 4; b++) pstrb[b] = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
        pkt[12] = 8'h08; pkt[13] = 8'h00; pkt[14] = 8'h45; pkt[23] = 8'd17;
        if (!good_hdr) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0: pkt[12] = 8'h86;
                1: pkt[13] = 8'h01;
                2: pkt[14] = 8'h46;
                default: pkt[23] = 8'd6;
            endcase
        end
        pkt[36] = cfg_dport[15:8];
        pkt[37] = cfg_dport[7:0];
        if (!good_port) pkt[37] = pkt[37] ^ 8'(1 << $urandom_range(0, 7));
        for (int i = 0; i < 8; i++) pkt[42+i] = 8'(ts >> (8 * (7 - i)));
        for (int i = 0; i < 4; i++) pkt[50+i] = 8'(sq >> (8 * (3 - i)));
    endtask

    task automatic drive_beat(input int b, input bit last, input bit clr);
        for (int n = 0; n < 32; n++) tdata[8*n +: 8] = pkt[b*32 + n];
        tstrb       = pstrb[b];
        tuser       = {$urandom, $urandom, $urandom, $urandom};
        tvalid      = 1'b1;
        tlast       = last;
        clear_stats = clr;
        @(posedge clk);
        #1;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input longint unsigned st, input int gap_max, input bit clr_last);
        stamp = st;
        if (clr_last) model_reset();
        else          model_packet(nb, st);
        exp_q.push_back(m);
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #1;
            drive_beat(b, b == nb - 1, clr_last && (b == nb - 1));
        end
    endtask

    // Monitor: every change of rx_packets marks a finished packet (or a clear)
    always @(negedge clk) begin
        snap_t e;
        if (!rst_n) begin
            prev_pk = 32'd0;
        end else if (rx_packets !== prev_pk) begin
            prev_pk = rx_packets;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: rx_packets=%0d with nothing expected", rx_packets);
            end else begin
                e = exp_q.pop_front();
                chk("rx_packets", {32'd0, rx_packets}, e.packets);
                chk("rx_matched", {32'd0, rx_matched}, e.matched);
                chk("rx_runts",   {32'd0, rx_runts},   e.runts);
                chk("rx_bytes",   {32'd0, rx_bytes},   e.bytes);
                chk("ts_errors",  {32'd0, ts_errors},  e.ts_err);
                chk("lat_last",   {32'd0, lat_last},   e.lat_last);
                chk("lat_min",    {32'd0, lat_min},    e.lat_min);
                chk("lat_max",    {32'd0, lat_max},    e.lat_max);
                chk("seq_errors", {32'd0, seq_errors}, e.seq_err);
            end
        end
    end

    initial begin
        longint unsigned st, ts;
        int unsigned     seq_run;
        int              w;
        rst_n = 1'b0; tdata = '0; tstrb = '0; tuser = '0; tvalid = 1'b0; tlast = 1'b0;
        stamp = '0; cfg_dport = 16'h9c59; clear_stats = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_tready",  {63'd0, tready},     64'd0);
        chk("reset_packets", {32'd0, rx_packets}, 64'd0);
        chk("reset_matched", {32'd0, rx_matched}, 64'd0);
        chk("reset_runts",   {32'd0, rx_runts},   64'd0);
        chk("reset_bytes",   {32'd0, rx_bytes},   64'd0);
        chk("reset_ts_err",  {32'd0, ts_errors},  64'd0);
        chk("reset_lat_last",{32'd0, lat_last},   64'd0);
        chk("reset_lat_min", {32'd0, lat_min},    64'hFFFF_FFFF);
        chk("reset_lat_max", {32'd0, lat_max},    64'd0);
        chk("reset_seq_err", {32'd0, seq_errors}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_reset", {63'd0, tready}, 64'd1);

        build_pkt(1, 1, 100, 0);  send_pkt(3, 350, 0, 0);
        build_pkt(1, 1, 100, 1);  pkt[36] = 8'h12; pkt[37] = 8'h34; send_pkt(3, 350, 0, 0);
        build_pkt(1, 1, 5, 2);    send_pkt(1, 20, 0, 0);
        build_pkt(1, 1, 30, 3);   send_pkt(3, 77, 3, 0);
        build_pkt(1, 1, 500, 4);  send_pkt(3, 400, 0, 0);
        build_pkt(1, 1, 0, 5);    send_pkt(2, 64'h2_0000_0000, 0, 0);
        build_pkt(1, 1, 960, 6);  send_pkt(3, 1000, 1, 0);
        build_pkt(1, 1, 1990, 7); send_pkt(3, 2000, 1, 0);
        build_pkt(1, 1, 2930, 8); send_pkt(3, 3000, 1, 0);
        build_pkt(0, 0, 0, 0);    send_pkt(2, 3100, 0, 1);
        build_pkt(1, 1, 10, 5);   send_pkt(3, 20, 0, 0);
        build_pkt(1, 1, 10, 6);   send_pkt(3, 20, 0, 0);
        build_pkt(1, 1, 10, 8);   send_pkt(4, 20, 0, 0);
        build_pkt(1, 1, 10, 9);   send_pkt(2, 20, 0, 0);

        seq_run = 100;
        for (int p = 0; p < 150; p++) begin
            st = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ts = st - longint'($urandom_range(0, 100000));
                1: ts = st - ({32'd0, $urandom} + 64'h1_0000_0000);
                2: ts = st + longint'($urandom_range(1, 1000));
                default: ts = st;
            endcase
            seq_run = ($urandom_range(0, 4) == 0) ? $urandom : seq_run + 1;
            build_pkt($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ts, seq_run);
            send_pkt(int'($urandom_range(1, 4)), st, 2,
                     (m.packets != 0) && ($urandom_range(0, 19) == 0));
        end

        // Reset in the middle of a packet: the tail is parsed as a new packet
        build_pkt(1, 1, 100, 0);
        stamp = 350;
        #1 drive_beat(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("midreset_tready",  {63'd0, tready},     64'd0);
        chk("midreset_packets", {32'd0, rx_packets}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 96; i++) pkt[i] = pkt[i+32];
        for (int b = 0; b < 3; b++) pstrb[b] = pstrb[b+1];
        send_pkt(2, 350, 0, 0);
        build_pkt(1, 1, 100, 0);
        send_pkt(3, 350, 0, 0);

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected packets never observed, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
